// File: rtl/fourier_harmonic_sequencer.sv
// rtl/fourier_harmonic_sequencer.sv - time-multiplexed odd-harmonic square-wave sample sequencer
//
// Purpose: on each accepted sample tick, walks one shared sine LUT port through
// harmonics n = 1,3,5,... and accumulates (lut_data * round(1024/n)) >>> 10 into
// one signed sample. Owns the fundamental phase accumulator.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   enable, sample_tick   tick is accepted only when idle and enabled
//   phase_step, num_harm  sampled on the accept cycle only
//   lut_en, lut_addr      LUT read strobe/address (one read per harmonic)
//   lut_data              signed LUT data, valid one cycle after lut_en
//   busy                  high whenever a sample is in flight
//   sample_out            summed sample, held until the next result
//   sample_valid          one-cycle pulse when sample_out updates
//   overrun               one-cycle pulse after a tick rejected while busy
//   ovr_count             saturating overrun count (FOURIER_SEQ_OVR_CNT_EN only)
//
// Build option: define FOURIER_SEQ_OVR_CNT_EN to add the ovr_count output.

module fourier_harmonic_sequencer #(
    parameter int PHASE_WIDTH   = 16,
    parameter int LUT_BITS      = 12,
    parameter int MAX_HARMONICS = 8,
    parameter int HW            = 4,
    parameter int ACC_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   sample_tick,
    input  logic [PHASE_WIDTH-1:0] phase_step,
    input  logic [HW-1:0]          num_harm,
    output logic                   lut_en,
    output logic [LUT_BITS-1:0]    lut_addr,
    input  logic [8:0]             lut_data,
    output logic                   busy,
    output logic [ACC_W-1:0]       sample_out,
    output logic                   sample_valid,
`ifdef FOURIER_SEQ_OVR_CNT_EN
    output logic [7:0]             ovr_count,
`endif
    output logic                   overrun
);

    localparam int IDX_W = (MAX_HARMONICS > 1) ? $clog2(MAX_HARMONICS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Rounded reciprocal of harmonic n = 2h+1 in Q10.
    function automatic logic [10:0] recip(input int h);
        int n;
        n = 2 * h + 1;
        return 11'((1024 + (n >> 1)) / n);
    endfunction

    logic [10:0] r_tab [MAX_HARMONICS];
    for (genvar g = 0; g < MAX_HARMONICS; g++) begin : g_rtab
        assign r_tab[g] = recip(g);
    end

    logic [1:0]             state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_acc_q, phase_acc_d;
    logic [PHASE_WIDTH-1:0] hstep_q, hstep_d;     // 2 * cur_phase, the per-harmonic phase stride
    logic [PHASE_WIDTH-1:0] hphase_q, hphase_d;
    logic [IDX_W-1:0]       issue_q, issue_d;
    logic [IDX_W-1:0]       h_last_q, h_last_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       sample_out_q, sample_out_d;
    logic                   rd_pend_q;            // a LUT read issued last cycle returns now
    logic [IDX_W-1:0]       rd_idx_q;
    logic                   overrun_q;

    logic                   accept;
    logic                   ovr_set;
    logic [HW-1:0]          h_eff;
    logic signed [20:0]     prod;
    logic [ACC_W-1:0]       term;
    logic [ACC_W-1:0]       acc_sum;

    assign accept  = (state_q == IDLE) && enable && sample_tick;
    assign ovr_set = (state_q != IDLE) && enable && sample_tick;

    always_comb begin
        h_eff = num_harm;
        if (num_harm == '0) begin
            h_eff = HW'(1);
        end else if (num_harm > HW'(MAX_HARMONICS)) begin
            h_eff = HW'(MAX_HARMONICS);
        end
    end

    // Arithmetic shift of the signed product gives floor rounding.
    assign prod    = $signed(lut_data) * $signed({1'b0, r_tab[rd_idx_q]});
    assign term    = ACC_W'(prod >>> 10);
    assign acc_sum = acc_q + (rd_pend_q ? term : '0);

    always_comb begin
        state_d      = state_q;
        phase_acc_d  = phase_acc_q;
        hstep_d      = hstep_q;
        hphase_d     = hphase_q;
        issue_d      = issue_q;
        h_last_d     = h_last_q;
        acc_d        = acc_q;
        sample_out_d = sample_out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = RUN;
                    hphase_d    = phase_acc_q;
                    hstep_d     = {phase_acc_q[PHASE_WIDTH-2:0], 1'b0};
                    phase_acc_d = phase_acc_q + phase_step;
                    acc_d       = '0;
                    issue_d     = '0;
                    h_last_d    = IDX_W'(h_eff - HW'(1));
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                hphase_d = hphase_q + hstep_q;
                if (issue_q == h_last_q) begin
                    state_d = DRAIN;
                end else begin
                    issue_d = issue_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                acc_d        = acc_sum;
                sample_out_d = acc_sum;
                state_d      = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_acc_q  <= '0;
            hstep_q      <= '0;
            hphase_q     <= '0;
            issue_q      <= '0;
            h_last_q     <= '0;
            acc_q        <= '0;
            sample_out_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_acc_q  <= phase_acc_d;
            hstep_q      <= hstep_d;
            hphase_q     <= hphase_d;
            issue_q      <= issue_d;
            h_last_q     <= h_last_d;
            acc_q        <= acc_d;
            sample_out_q <= sample_out_d;
            rd_pend_q    <= (state_q == RUN);
            rd_idx_q     <= issue_q;
            overrun_q    <= ovr_set;
        end
    end

`ifdef FOURIER_SEQ_OVR_CNT_EN
    logic [7:0] ovr_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= 8'd0;
        end else if (ovr_set && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end
    assign ovr_count = ovr_cnt_q;
`endif

    assign lut_en       = (state_q == RUN);
    assign lut_addr     = (state_q == RUN) ? hphase_q[PHASE_WIDTH-1 -: LUT_BITS] : '0;
    assign busy         = (state_q != IDLE);
    assign sample_valid = (state_q == DONE);
    assign sample_out   = sample_out_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_fourier_harmonic_sequencer.sv
// tb/tb_fourier_harmonic_sequencer.sv - self-checking bench for fourier_harmonic_sequencer

module tb_fourier_harmonic_sequencer;

    localparam int MH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_tick;
    logic [15:0] phase_step;
    logic [3:0]  num_harm;
    logic        lut_en;
    logic [11:0] lut_addr;
    logic [8:0]  lut_data = 9'd0;
    logic        busy;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        overrun;
`ifdef FOURIER_SEQ_OVR_CNT_EN
    logic [7:0]  ovr_count;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    int          lut_mode = 0;
    logic [15:0] phase_model = 16'd0;

    fourier_harmonic_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_tick  (sample_tick),
        .phase_step   (phase_step),
        .num_harm     (num_harm),
        .lut_en       (lut_en),
        .lut_addr     (lut_addr),
        .lut_data     (lut_data),
        .busy         (busy),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
`ifdef FOURIER_SEQ_OVR_CNT_EN
        .ovr_count    (ovr_count),
`endif
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] lut_fn(input int mode, input logic [11:0] a);
        logic [8:0] v;
        case (mode)
            0:       v = 9'd100;
            1:       v = 9'h19C;   // -100
            default: v = 9'((int'(a) * 113) ^ (int'(a) >> 3));
        endcase
        return v;
    endfunction

    // One-cycle-latency LUT; garbage on the bus when not reading.
    always @(posedge clk) begin
        if (lut_en) lut_data <= lut_fn(lut_mode, lut_addr);
        else        lut_data <= 9'($urandom);
    end

    function automatic int eff_h(input logic [3:0] nh);
        if (nh == 0) return 1;
        if (int'(nh) > MH) return MH;
        return int'(nh);
    endfunction

    function automatic logic [11:0] ref_addr(input logic [15:0] p, input int k);
        logic [15:0] hp;
        hp = 16'((2 * k + 1) * int'(p));
        return hp[15:4];
    endfunction

    function automatic logic [15:0] ref_sample(input logic [15:0] p, input int h);
        int acc, n, r, d;
        acc = 0;
        for (int k = 0; k < h; k++) begin
            n = 2 * k + 1;
            r = (1024 + (n >> 1)) / n;
            d = int'($signed(lut_fn(lut_mode, ref_addr(p, k))));
            acc += (d * r) >>> 10;
        end
        return 16'(acc);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        phase_model = 16'd0;
    endtask

    task automatic do_sample(input logic [15:0] step, input logic [3:0] nh, input bit drop_en);
        int h;
        logic [15:0] p, exp_s;
        h = eff_h(nh);
        p = phase_model;
        exp_s = ref_sample(p, h);
        @(negedge clk);
        enable = 1'b1;
        sample_tick = 1'b1;
        phase_step = step;
        num_harm = nh;
        @(negedge clk);
        sample_tick = 1'b0;
        phase_step = 16'($urandom);
        num_harm = 4'($urandom);
        if (drop_en) enable = 1'b0;
        phase_model = p + step;
        for (int j = 1; j <= h + 2; j++) begin
            if (j > 1) @(negedge clk);
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy j=%0d got %b want 1", j, busy);
            end
            tests_run++;
            if (lut_en !== (j <= h)) begin
                tests_failed++;
                $display("FAIL lut_en j=%0d h=%0d got %b want %b", j, h, lut_en, (j <= h));
            end
            if (j <= h) begin
                tests_run++;
                if (lut_addr !== ref_addr(p, j - 1)) begin
                    tests_failed++;
                    $display("FAIL lut_addr phase=%h k=%0d got %h want %h", p, j - 1, lut_addr, ref_addr(p, j - 1));
                end
            end
            tests_run++;
            if (sample_valid !== (j == h + 2)) begin
                tests_failed++;
                $display("FAIL sample_valid j=%0d h=%0d got %b want %b", j, h, sample_valid, (j == h + 2));
            end
            tests_run++;
            if (overrun !== 1'b0) begin
                tests_failed++;
                $display("FAIL overrun_idle j=%0d got %b want 0", j, overrun);
            end
        end
        tests_run++;
        if (sample_out !== exp_s) begin
            tests_failed++;
            $display("FAIL sample_out phase=%h h=%0d mode=%0d got %h want %h", p, h, lut_mode, sample_out, exp_s);
        end
    endtask

    task automatic check_all_zero(input string tag);
        tests_run++;
        if ({lut_en, lut_addr, busy, sample_out, sample_valid, overrun} !== 31'd0) begin
            tests_failed++;
            $display("FAIL %s got en=%b addr=%h busy=%b out=%h vld=%b ovr=%b want all 0",
                     tag, lut_en, lut_addr, busy, sample_out, sample_valid, overrun);
        end
    endtask

    task automatic test_reset();
        #1;
        check_all_zero("reset_state");
        apply_reset();
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_const();
        lut_mode = 0;
        do_sample(16'h1234, 4'd3, 1'b0);
        tests_run++;
        if (sample_out !== 16'd153) begin
            tests_failed++;
            $display("FAIL const_pos got %0d want 153", $signed(sample_out));
        end
        lut_mode = 1;
        do_sample(16'h0777, 4'd3, 1'b0);
        tests_run++;
        if (sample_out !== 16'hFF65) begin
            tests_failed++;
            $display("FAIL const_neg got %0d want -155", $signed(sample_out));
        end
    endtask

    task automatic test_addr_seq();
        lut_mode = 2;
        apply_reset();
        do_sample(16'd256, 4'd3, 1'b0);
        do_sample(16'd0, 4'd3, 1'b0);
        apply_reset();
        do_sample(16'hC000, 4'd2, 1'b0);
        do_sample(16'h0100, 4'd2, 1'b0);
    endtask

    task automatic test_harm_limits();
        lut_mode = 2;
        do_sample(16'($urandom), 4'd0, 1'b0);
        do_sample(16'($urandom), 4'd15, 1'b0);
        do_sample(16'($urandom), 4'd8, 1'b0);
        do_sample(16'($urandom), 4'd1, 1'b0);
    endtask

    task automatic test_overrun();
        logic [15:0] p, s, exp_s;
        lut_mode = 2;
        p = phase_model;
        s = 16'($urandom);
        exp_s = ref_sample(p, 2);
        @(negedge clk);
        enable = 1'b1; sample_tick = 1'b1; phase_step = s; num_harm = 4'd2;
        @(negedge clk);
        sample_tick = 1'b0;
        phase_model = p + s;
        @(negedge clk);
        sample_tick = 1'b1; phase_step = 16'($urandom); num_harm = 4'd7;
        @(negedge clk);
        sample_tick = 1'b0;
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_pulse got %b want 1", overrun);
        end
        @(negedge clk);
        tests_run++;
        if (sample_valid !== 1'b1 || sample_out !== exp_s || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_result vld=%b out=%h ovr=%b want 1 %h 0", sample_valid, sample_out, overrun, exp_s);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_idle_after got busy=%b want 0", busy);
        end
    endtask

    task automatic test_enable_low();
        @(negedge clk);
        enable = 1'b0; sample_tick = 1'b1; phase_step = 16'($urandom | 1); num_harm = 4'd3;
        @(negedge clk);
        sample_tick = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || overrun !== 1'b0 || lut_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_low got busy=%b ovr=%b en=%b want 0 0 0", busy, overrun, lut_en);
        end
        do_sample(16'($urandom), 4'd4, 1'b0);
        do_sample(16'($urandom), 4'd4, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        enable = 1'b1; sample_tick = 1'b1; phase_step = 16'h4321; num_harm = 4'd4;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        phase_model = 16'd0;
        do_sample(16'($urandom), 4'd4, 1'b0);
        do_sample(16'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back();
        lut_mode = 2;
        for (int i = 0; i < 24; i++) begin
            do_sample(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

`ifdef FOURIER_SEQ_OVR_CNT_EN
    task automatic test_ovr_count();
        int seen;
        apply_reset();
        seen = 0;
        @(negedge clk);
        enable = 1'b1; sample_tick = 1'b1; num_harm = 4'd8;
        for (int c = 0; c < 600 && seen < 300; c++) begin
            @(negedge clk);
            if (overrun === 1'b1) seen++;
        end
        sample_tick = 1'b0;
        repeat (12) @(negedge clk);
        tests_run++;
        if (seen < 300 || ovr_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL ovr_count seen=%0d got %0d want 255", seen, ovr_count);
        end
        apply_reset();
        #1;
        tests_run++;
        if (ovr_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL ovr_count_reset got %0d want 0", ovr_count);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        sample_tick = 1'b0;
        phase_step = 16'd0;
        num_harm = 4'd0;
        test_reset();
        test_addr_seq();
        test_const();
        test_harm_limits();
        test_overrun();
        test_enable_low();
        test_reset_mid_run();
        test_back_to_back();
`ifdef FOURIER_SEQ_OVR_CNT_EN
        test_ovr_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fourier_harmonic_sequencer.md
Name: fourier_harmonic_sequencer

Overview:
Time-multiplexed scheduler for the odd-harmonic square-wave synthesis datapath. On each sample tick it sequences one shared external sine LUT port through harmonics n=1,3,5,… and accumulates sine(n·phase)·(1/n) terms, replacing per-harmonic parallel LUT reads. It owns the fundamental phase accumulator and delivers one signed summed sample per tick to the downstream normalisation/clip stage.

Parameters:
PHASE_WIDTH, 16, fundamental/harmonic phase width (bits)
LUT_BITS, 12, sine LUT address width; address = top LUT_BITS of harmonic phase
MAX_HARMONICS, 8, maximum odd harmonics per sample (≥1)
HW, 4, width of num_harm (must hold MAX_HARMONICS)
ACC_W, 16, signed accumulator / sample_out width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  accept sample ticks when high
sample_tick  in  1  one-cycle pulse requesting a new sample
phase_step  in  PHASE_WIDTH  phase increment, sampled on accepted tick
num_harm  in  HW  harmonic count, sampled on accepted tick
lut_en  out  1  LUT read strobe
lut_addr  out  LUT_BITS  LUT read address
lut_data  in  9  signed LUT data, valid exactly 1 cycle after lut_en
busy  out  1  high whenever state != IDLE
sample_out  out  ACC_W  signed summed sample, held until next result
sample_valid  out  1  one-cycle pulse, sample_out updated
overrun  out  1  one-cycle pulse, tick rejected because busy

Behaviour:
- Reset (rst_n low, any time, incl. mid-sequence): state IDLE, phase accumulator 0, accumulator 0, lut_en 0, lut_addr 0, busy 0, sample_out 0, sample_valid 0, overrun 0. Outstanding LUT read discarded.
- Effective harmonic count H: num_harm=0 → 1; num_harm>MAX_HARMONICS → MAX_HARMONICS; else num_harm. Latched at accept.
- Accept: state IDLE & enable & sample_tick in cycle T. Latch cur_phase = phase_acc; phase_acc <= phase_acc + phase_step (mod 2^PHASE_WIDTH). First sample after reset uses phase 0. Clear accumulator.
- States: IDLE → RUN (T+1..T+H) → DRAIN (T+H+1) → DONE (T+H+2) → IDLE.
- RUN: cycle T+1+h issues harmonic h (n=2h+1): lut_en=1, lut_addr = hphase[PHASE_WIDTH-1 -: LUT_BITS]. hphase starts at cur_phase, += 2·cur_phase each step (mod 2^PHASE_WIDTH); no multiplier.
- Accumulate in cycle after each issue: term = (lut_data · R[h]) >>> 10 (arithmetic, floor); acc += term, ACC_W wrap (no saturation). R[h] = floor((1024 + (n>>1))/n), elaboration-time constant table: R = 1024, 341, 205, 146, 114, 93, 79, 68, …
- DRAIN: lut_en=0, final term accumulated. DONE: sample_out <= acc registered so sample_valid=1 and new sample_out visible in cycle T+H+2; busy still 1.
- Latency tick→sample_valid = H+2 cycles; minimum tick spacing H+3 cycles.
- sample_tick while state != IDLE: ignored; overrun pulses next cycle if enable high. Tick with enable low: ignored, no overrun, phase not advanced.
- enable deasserted mid-sequence: sequence completes normally.
- phase_step/num_harm changes outside accept cycle: no effect on current sample.

Optional Feature:
FOURIER_SEQ_OVR_CNT_EN: defined → extra output ovr_count [7:0], saturating (stops at 255) count of overrun pulses, reset 0, cleared by rst_n only. Undefined → port absent, overrun pulse only; all other behaviour identical.

Test Plan:
- Reset mid-RUN (H=4, assert rst_n low at T+2) → all outputs 0 immediately; next tick uses phase 0, lut_addr 0.
- LUT model returns constant +100, num_harm=3, tick → terms 100,33,20; sample_valid at T+5 with sample_out=153; busy high T+1..T+5.
- Constant −100, num_harm=3 → terms −100,−34,−21; sample_out=−155 (floor rounding check).
- phase_step=256, num_harm=3, two ticks → first sample lut_addr 0,0,0; second 16,48,80.
- Wrap: phase_step=0xC000, second tick, num_harm=2 → lut_addr 0xC00 then 0x400.
- Tick during busy (H=2) at T+2 → overrun pulse at T+3, result unchanged at T+4; num_harm=0 → one lut_en; num_harm=15 → 8 lut_en pulses; with FOURIER_SEQ_OVR_CNT_EN, 300 overruns → ovr_count=255.
